// File: rtl/path_delay_meter.sv
// Launch/capture delay meter for one path under test: toggles the path input, counts
// clk cycles until the synchronised output moves, and accumulates TRIALS results.
// Optional per-run min/max tracking is built when DELAY_MINMAX_EN is defined.
`timescale 1ns/1ps
module path_delay_meter #(
   parameter int CNT_W   = 16,
   parameter int TRIALS  = 16,
   parameter int TIMEOUT = 1023,
   parameter int SETTLE  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              pathInput,
   input  logic                              pathResult,
   output logic                              busy,
   output logic                              done,
   output logic                              timeoutFlag,
   output logic [CNT_W+$clog2(TRIALS)-1:0]   delaySum,
   output logic [CNT_W-1:0]                  delayMin,
   output logic [CNT_W-1:0]                  delayMax
);

   localparam int SUM_W = CNT_W + $clog2(TRIALS);
   localparam int TW    = $clog2(TRIALS);
   localparam int SW    = $clog2(SETTLE + 1);

   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [TW-1:0]    TRIAL_LAST  = TW'(TRIALS - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RECORD = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]       r_state;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_baseline;
   logic             r_pathInput;
   logic             r_busy;
   logic             r_done;
   logic             r_timeoutFlag;
   logic [SUM_W-1:0] r_delaySum;
   logic [CNT_W-1:0] r_cnt;
   logic [TW-1:0]    r_trial;
   logic [SW-1:0]    r_settleCnt;
   logic             w_syncRes;

   // pathResult is asynchronous; its two-flop latency stays inside every count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pathResult;
         r_sync2 <= r_sync1;
      end
   end

   assign w_syncRes = r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_pathInput   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeoutFlag <= 1'b0;
         r_delaySum    <= '0;
         r_cnt         <= '0;
         r_trial       <= '0;
         r_settleCnt   <= '0;
         r_baseline    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_delaySum    <= '0;
                  r_timeoutFlag <= 1'b0;
                  r_trial       <= '0;
                  r_settleCnt   <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_settleCnt == SETTLE_LAST) begin
                  r_baseline <= w_syncRes;
                  r_state    <= S_LAUNCH;
               end else begin
                  r_settleCnt <= r_settleCnt + 1'b1;
               end
            end
            S_LAUNCH: begin
               r_pathInput <= ~r_pathInput;
               r_cnt       <= CNT_W'(1);
               r_state     <= S_WAIT;
            end
            // Comparing against the baseline rather than an expected level
            // makes inverting and non-inverting paths measure the same way.
            S_WAIT: begin
               if (w_syncRes != r_baseline) begin
                  r_state <= S_RECORD;
               end else if (r_cnt == TIMEOUT_C) begin
                  r_timeoutFlag <= 1'b1;
                  r_state       <= S_RECORD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RECORD: begin
               r_delaySum <= r_delaySum + SUM_W'(r_cnt);
               if (r_trial == TRIAL_LAST) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_trial     <= r_trial + 1'b1;
                  r_settleCnt <= '0;
                  r_state     <= S_SETTLE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef DELAY_MINMAX_EN
   logic [CNT_W-1:0] r_delayMin;
   logic [CNT_W-1:0] r_delayMax;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_delayMin <= '1;
         r_delayMax <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_delayMin <= '1;
         r_delayMax <= '0;
      end else if (r_state == S_RECORD) begin
         if (r_cnt < r_delayMin) r_delayMin <= r_cnt;
         if (r_cnt > r_delayMax) r_delayMax <= r_cnt;
      end
   end

   assign delayMin = r_delayMin;
   assign delayMax = r_delayMax;
`else
   assign delayMin = '0;
   assign delayMax = '0;
`endif

   assign pathInput   = r_pathInput;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeoutFlag = r_timeoutFlag;
   assign delaySum    = r_delaySum;

endmodule

// File: tb/tb_path_delay_meter.sv
// Self-checking bench for path_delay_meter: two instances (16-trial default, 4-trial with
// short timeout) driving behavioural delay-path models; expectations come from trial arithmetic.
`timescale 1ns/1ps
module tb_path_delay_meter;

   localparam int SETTLE_T = 8;
   localparam int LIMIT    = 20000;

   logic        clk = 1'b0;
   logic        rstA, startA, pathInputA, pathResultA, busyA, doneA, toA;
   logic [19:0] sumA;
   logic [15:0] minA, maxA;
   logic        rstB, startB, pathInputB, pathResultB, busyB, doneB, toB;
   logic [17:0] sumB;
   logic [15:0] minB, maxB;

   int checkCnt = 0;
   int passCnt  = 0;

   // Path models: output follows input after D cycles minus half a cycle (mid-cycle edge).
   logic rawA = 1'b0, rawB = 1'b0;
   int   dlyA = 3, dlyB = 3;
   bit   invA = 0, stuckA = 0, stuckB = 0, altB = 0;
   int   togA = 0, togB = 0, baseA = 0, baseB = 0;

   always #5 clk = ~clk;

   always @(pathInputA) begin
      automatic logic v  = pathInputA;
      automatic int   dl = dlyA * 10 - 5;
      togA++;
      fork
         begin
            #(dl);
            rawA = v;
         end
      join_none
   end

   always @(pathInputB) begin
      automatic logic v  = pathInputB;
      automatic int   dl = (altB ? ((((togB - baseB) % 2) == 0) ? 2 : 6) : dlyB) * 10 - 5;
      togB++;
      fork
         begin
            #(dl);
            rawB = v;
         end
      join_none
   end

   assign pathResultA = stuckA ? 1'b0 : (invA ? ~rawA : rawA);
   assign pathResultB = stuckB ? 1'b0 : rawB;

   path_delay_meter u_dutA (
      .clk(clk), .rst(rstA), .start(startA), .pathInput(pathInputA),
      .pathResult(pathResultA), .busy(busyA), .done(doneA), .timeoutFlag(toA),
      .delaySum(sumA), .delayMin(minA), .delayMax(maxA)
   );

   path_delay_meter #(.CNT_W(16), .TRIALS(4), .TIMEOUT(20), .SETTLE(SETTLE_T)) u_dutB (
      .clk(clk), .rst(rstB), .start(startB), .pathInput(pathInputB),
      .pathResult(pathResultB), .busy(busyB), .done(doneB), .timeoutFlag(toB),
      .delaySum(sumB), .delayMin(minB), .delayMax(maxB)
   );

   // Reference: each trial counts D+2 cycles (capped at the timeout); a trial occupies
   // SETTLE + launch + count + record cycles, and busy adds one DONE cycle.
   function automatic void model(input int trials, input int timeout, input bit stuck,
                                 input bit alt, input int d, output int sum,
                                 output int mn, output int mx, output int busyCyc);
      sum = 0; mn = 65535; mx = 0; busyCyc = 1;
      for (int t = 0; t < trials; t++) begin
         automatic int dd = alt ? (((t % 2) == 0) ? 2 : 6) : d;
         automatic int c  = stuck ? timeout : dd + 2;
         if (c > timeout) c = timeout;
         sum += c;
         if (c < mn) mn = c;
         if (c > mx) mx = c;
         busyCyc += c + SETTLE_T + 2;
      end
`ifndef DELAY_MINMAX_EN
      mn = 0;
      mx = 0;
`endif
   endfunction

   task automatic runA(input int startAt, output int sum, output int to, output int mn,
                       output int mx, output int bc, output int dc, output int di,
                       output int hung);
      int n;
      baseA = togA;
      @(negedge clk) startA = 1'b1;
      @(negedge clk) startA = 1'b0;
      bc = 0; dc = 0; di = -1; n = 0;
      while (busyA && n < LIMIT) begin
         bc++;
         if (doneA) begin dc++; di = bc; end
         startA = (bc == startAt);
         @(negedge clk);
         n++;
      end
      startA = 1'b0;
      if (doneA) dc++;
      hung = (n >= LIMIT);
      sum = int'(sumA); to = int'(toA); mn = int'(minA); mx = int'(maxA);
   endtask

   task automatic runB(output int sum, output int to, output int mn, output int mx,
                       output int bc, output int dc, output int hung);
      int n;
      baseB = togB;
      @(negedge clk) startB = 1'b1;
      @(negedge clk) startB = 1'b0;
      bc = 0; dc = 0; n = 0;
      while (busyB && n < LIMIT) begin
         bc++;
         if (doneB) dc++;
         @(negedge clk);
         n++;
      end
      hung = (n >= LIMIT);
      sum = int'(sumB); to = int'(toB); mn = int'(minB); mx = int'(maxB);
   endtask

   task automatic test_reset;
      int expMin;
`ifdef DELAY_MINMAX_EN
      expMin = 65535;
`else
      expMin = 0;
`endif
      rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
      repeat (4) @(negedge clk);
      rstA = 1'b0; rstB = 1'b0;
      @(negedge clk);
      checkCnt++; if (busyA !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busyA); else passCnt++;
      checkCnt++; if (pathInputA !== 1'b0) $display("[TB] FAIL reset_pathInput: got %b want 0", pathInputA); else passCnt++;
      checkCnt++; if (doneA !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", doneA); else passCnt++;
      checkCnt++; if (toA !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", toA); else passCnt++;
      checkCnt++; if (sumA !== 20'd0) $display("[TB] FAIL reset_sum: got %0d want 0", sumA); else passCnt++;
      checkCnt++; if (int'(minA) !== expMin) $display("[TB] FAIL reset_min: got %0d want %0d", minA, expMin); else passCnt++;
      checkCnt++; if (maxA !== 16'd0) $display("[TB] FAIL reset_max: got %0d want 0", maxA); else passCnt++;
      checkCnt++; if (busyB !== 1'b0 || sumB !== 18'd0) $display("[TB] FAIL reset_B: got busy %b sum %0d want 0/0", busyB, sumB); else passCnt++;
   endtask

   task automatic test_noninverting;
      int s, to, mn, mx, bc, dc, di, h, es, emn, emx, ebc;
      invA = 0; dlyA = 3;
      repeat (5) @(negedge clk);
      model(16, 1023, 0, 0, 3, es, emn, emx, ebc);
      runA(-1, s, to, mn, mx, bc, dc, di, h);
      checkCnt++; if (h !== 0) $display("[TB] FAIL noninv_hang: got busy stuck want done"); else passCnt++;
      checkCnt++; if (s !== es) $display("[TB] FAIL noninv_sum: got %0d want %0d", s, es); else passCnt++;
      checkCnt++; if (to !== 0) $display("[TB] FAIL noninv_timeout: got %0d want 0", to); else passCnt++;
      checkCnt++; if (mn !== emn || mx !== emx) $display("[TB] FAIL noninv_minmax: got %0d/%0d want %0d/%0d", mn, mx, emn, emx); else passCnt++;
      checkCnt++; if (bc !== ebc) $display("[TB] FAIL noninv_busy_cycles: got %0d want %0d", bc, ebc); else passCnt++;
      checkCnt++; if (dc !== 1 || di !== ebc) $display("[TB] FAIL noninv_done: got count %0d at %0d want 1 at %0d", dc, di, ebc); else passCnt++;
   endtask

   task automatic test_inverting;
      int s, to, mn, mx, bc, dc, di, h, es, emn, emx, ebc;
      invA = 1; dlyA = 3;
      repeat (5) @(negedge clk);
      model(16, 1023, 0, 0, 3, es, emn, emx, ebc);
      runA(-1, s, to, mn, mx, bc, dc, di, h);
      checkCnt++; if (s !== es || h !== 0) $display("[TB] FAIL inv_sum: got %0d want %0d", s, es); else passCnt++;
      checkCnt++; if (to !== 0) $display("[TB] FAIL inv_timeout: got %0d want 0", to); else passCnt++;
      checkCnt++; if (bc !== ebc) $display("[TB] FAIL inv_busy_cycles: got %0d want %0d", bc, ebc); else passCnt++;
      invA = 0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_timeout;
      int s, to, mn, mx, bc, dc, h, es, emn, emx, ebc;
      stuckB = 1; altB = 0;
      repeat (3) @(negedge clk);
      model(4, 20, 1, 0, 0, es, emn, emx, ebc);
      runB(s, to, mn, mx, bc, dc, h);
      checkCnt++; if (s !== es || h !== 0) $display("[TB] FAIL timeout_sum: got %0d want %0d", s, es); else passCnt++;
      checkCnt++; if (to !== 1) $display("[TB] FAIL timeout_flag: got %0d want 1", to); else passCnt++;
      checkCnt++; if (bc !== ebc) $display("[TB] FAIL timeout_busy_cycles: got %0d want %0d", bc, ebc); else passCnt++;
      checkCnt++; if (dc !== 1) $display("[TB] FAIL timeout_done: got %0d pulses want 1", dc); else passCnt++;
      stuckB = 0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_alternating;
      int s, to, mn, mx, bc, dc, h, es, emn, emx, ebc;
      altB = 1;
      model(4, 20, 0, 1, 0, es, emn, emx, ebc);
      runB(s, to, mn, mx, bc, dc, h);
      checkCnt++; if (s !== es || h !== 0) $display("[TB] FAIL alt_sum: got %0d want %0d", s, es); else passCnt++;
      checkCnt++; if (to !== 0) $display("[TB] FAIL alt_timeout: got %0d want 0 (previous run must be cleared)", to); else passCnt++;
      checkCnt++; if (mn !== emn) $display("[TB] FAIL alt_min: got %0d want %0d", mn, emn); else passCnt++;
      checkCnt++; if (mx !== emx) $display("[TB] FAIL alt_max: got %0d want %0d", mx, emx); else passCnt++;
      checkCnt++; if (bc !== ebc) $display("[TB] FAIL alt_busy_cycles: got %0d want %0d", bc, ebc); else passCnt++;
      altB = 0;
   endtask

   task automatic test_reset_mid_run;
      int n, sawDone, s, to, mn, mx, bc, dc, di, h, es, emn, emx, ebc;
      dlyA = 3; invA = 0;
      baseA = togA;
      @(negedge clk) startA = 1'b1;
      @(negedge clk) startA = 1'b0;
      n = 0; sawDone = 0;
      while ((togA - baseA) < 3 && n < LIMIT) begin
         if (doneA) sawDone = 1;
         @(negedge clk);
         n++;
      end
      checkCnt++; if (n >= LIMIT) $display("[TB] FAIL midrst_reach_trial2: got no third launch want launch"); else passCnt++;
      repeat (2) @(negedge clk);
      rstA = 1'b1;
      @(negedge clk);
      rstA = 1'b0;
      checkCnt++; if (busyA !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busyA); else passCnt++;
      checkCnt++; if (pathInputA !== 1'b0) $display("[TB] FAIL midrst_pathInput: got %b want 0", pathInputA); else passCnt++;
      checkCnt++; if (sumA !== 20'd0) $display("[TB] FAIL midrst_sum: got %0d want 0", sumA); else passCnt++;
      repeat (20) begin
         if (doneA) sawDone = 1;
         @(negedge clk);
      end
      checkCnt++; if (sawDone !== 0) $display("[TB] FAIL midrst_no_done: got done pulse want none"); else passCnt++;
      model(16, 1023, 0, 0, 3, es, emn, emx, ebc);
      runA(-1, s, to, mn, mx, bc, dc, di, h);
      checkCnt++; if (s !== es || to !== 0 || h !== 0) $display("[TB] FAIL midrst_rerun: got sum %0d to %0d want %0d 0", s, to, es); else passCnt++;
   endtask

   task automatic test_start_while_busy;
      int s, to, mn, mx, bc, dc, di, h, es, emn, emx, ebc, at;
      model(16, 1023, 0, 0, 3, es, emn, emx, ebc);
      at = $urandom_range(ebc - 2, 2);
      runA(at, s, to, mn, mx, bc, dc, di, h);
      checkCnt++; if (bc !== ebc || h !== 0) $display("[TB] FAIL busy_start_cycles: got %0d want %0d (pulse at %0d)", bc, ebc, at); else passCnt++;
      checkCnt++; if (dc !== 1 || di !== ebc) $display("[TB] FAIL busy_start_done: got %0d at %0d want 1 at %0d", dc, di, ebc); else passCnt++;
      checkCnt++; if (s !== es) $display("[TB] FAIL busy_start_sum: got %0d want %0d", s, es); else passCnt++;
      repeat (4) @(negedge clk);
      checkCnt++; if (busyA !== 1'b0) $display("[TB] FAIL busy_start_restart: got busy %b want 0", busyA); else passCnt++;
   endtask

   task automatic test_start_with_reset;
      @(negedge clk);
      rstA = 1'b1; startA = 1'b1;
      @(negedge clk);
      rstA = 1'b0; startA = 1'b0;
      checkCnt++; if (busyA !== 1'b0) $display("[TB] FAIL start_rst_busy: got %b want 0", busyA); else passCnt++;
      @(negedge clk);
      checkCnt++; if (busyA !== 1'b0) $display("[TB] FAIL start_rst_idle: got %b want 0", busyA); else passCnt++;
   endtask

   initial begin
      rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
      test_reset();
      test_noninverting();
      test_inverting();
      test_timeout();
      test_alternating();
      test_reset_mid_run();
      test_start_while_busy();
      test_start_with_reset();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
